// File: rtl/lsu_align_if.sv
// Request/response handshake bundle between the execute stage and lsu_align.
interface lsu_align_if #(
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/lsu_align.sv
// Load/store alignment unit: turns byte-addressed RV32 loads/stores into
// whole-word accesses on a word-indexed memory. Sub-word stores are done as
// read-modify-write; misaligned or illegal accesses get an error response.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// READ  | memory word being read (load result or merge base)
// WRITE | merged/full word being written
// RESP  | response held until resp_ready
module lsu_align #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  lsu_align_if.slave            bus,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [2:0]            mem_funct3,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t                st;
  logic                  we_q;
  logic [2:0]            f3_q;
  logic [1:0]            off_q;
  logic [DM_ADDRESS-1:0] idx_q;
  logic [DATA_W-1:0]     wdata_q;

  logic [DM_ADDRESS-1:0] req_idx;
  logic [1:0]            req_off;
  logic                  req_err;
  logic                  addr_hi_unused;

  assign mem_funct3     = 3'b010;
  assign req_idx        = bus.req_addr[DM_ADDRESS+1:2];
  assign req_off        = bus.req_addr[1:0];
  // Upper address bits are dropped so accesses wrap modulo memory size.
  assign addr_hi_unused = ^bus.req_addr[31:DM_ADDRESS+2];

  function automatic logic access_err(input logic we, input logic [2:0] f3,
                                      input logic [1:0] off);
    logic e;
    case (f3)
      3'b000:  e = 1'b0;
      3'b001:  e = off[0];
      3'b010:  e = (off != 2'b00);
      3'b100:  e = we;
      3'b101:  e = we | off[0];
      default: e = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] w,
                                               input logic [2:0] f3,
                                               input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] base,
                                              input logic [31:0] wd,
                                              input logic [2:0] f3,
                                              input logic [1:0] off);
    logic [31:0] r;
    r = base;
    if (f3 == 3'b000) begin
      case (off)
        2'd0:    r[7:0]   = wd[7:0];
        2'd1:    r[15:8]  = wd[7:0];
        2'd2:    r[23:16] = wd[7:0];
        default: r[31:24] = wd[7:0];
      endcase
    end else if (f3 == 3'b001) begin
      if (off[1]) r[31:16] = wd[15:0];
      else        r[15:0]  = wd[15:0];
    end else begin
      r = wd;
    end
    return r;
  endfunction

  assign req_err = access_err(bus.req_we, bus.req_funct3, req_off);

  // Sequencer: all outputs are registered alongside the state transitions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st             <= IDLE;
      we_q           <= 1'b0;
      f3_q           <= 3'd0;
      off_q          <= 2'd0;
      idx_q          <= '0;
      wdata_q        <= '0;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
      bus.resp_rdata <= '0;
      mem_re         <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
    end else begin
      case (st)
        IDLE: begin
          if (bus.req_valid) begin
            we_q          <= bus.req_we;
            f3_q          <= bus.req_funct3;
            off_q         <= req_off;
            idx_q         <= req_idx;
            wdata_q       <= bus.req_wdata;
            bus.req_ready <= 1'b0;
            if (req_err) begin
              st             <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= '0;
            end else if (bus.req_we && bus.req_funct3 == 3'b010) begin
              st        <= WRITE;
              mem_we    <= 1'b1;
              mem_addr  <= req_idx;
              mem_wdata <= bus.req_wdata;
            end else begin
              st       <= READ;
              mem_re   <= 1'b1;
              mem_addr <= req_idx;
            end
          end
        end
        READ: begin
          mem_re <= 1'b0;
          if (we_q) begin
            // The merge base is the word read this cycle; nobody else may
            // write the memory between here and the WRITE cycle.
            st        <= WRITE;
            mem_we    <= 1'b1;
            mem_wdata <= store_merge(mem_rdata, wdata_q, f3_q, off_q);
          end else begin
            st             <= RESP;
            mem_addr       <= '0;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= load_extract(mem_rdata, f3_q, off_q);
          end
        end
        WRITE: begin
          st             <= RESP;
          mem_we         <= 1'b0;
          mem_addr       <= '0;
          mem_wdata      <= '0;
          bus.resp_valid <= 1'b1;
          bus.resp_err   <= 1'b0;
          bus.resp_rdata <= '0;
        end
        default: begin
          if (bus.resp_ready) begin
            st             <= IDLE;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_align.sv
module tb_lsu_align;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_re, mem_we;
  logic [2:0]  mem_funct3;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        preload = 1'b1;
  logic [31:0] mem [0:511];

  lsu_align_if #(.DATA_W(32)) bus();

  lsu_align #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .mem_re(mem_re), .mem_we(mem_we), .mem_funct3(mem_funct3),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (preload) begin
      mem[0] <= 32'd0;
      mem[3] <= 32'h812345F6;
      mem[4] <= 32'd0;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          re;
    int          we;
    logic [8:0]  wa;
    logic [31:0] wd;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_rst(input string tag);
    chk({tag, " req_ready"}, {31'd0, bus.req_ready}, 32'd1);
    chk({tag, " resp_valid"}, {31'd0, bus.resp_valid}, 32'd0);
    chk({tag, " resp_err"}, {31'd0, bus.resp_err}, 32'd0);
    chk({tag, " resp_rdata"}, bus.resp_rdata, 32'd0);
    chk({tag, " mem_re"}, {31'd0, mem_re}, 32'd0);
    chk({tag, " mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, " mem_addr"}, {23'd0, mem_addr}, 32'd0);
    chk({tag, " mem_wdata"}, mem_wdata, 32'd0);
  endtask

  // Monitor: counts memory activity per transaction and scores each response.
  int          ncyc = 0, acc_n = 0, re_cnt = 0, we_cnt = 0;
  logic        seen = 1'b0;
  logic [8:0]  last_wa;
  logic [31:0] last_wd, held_rdata;
  logic        held_err;
  exp_t        e;

  always @(negedge clk) begin
    ncyc++;
    if (mem_re) re_cnt++;
    if (mem_we) begin
      we_cnt++;
      last_wa = mem_addr;
      last_wd = mem_wdata;
    end
    if (bus.resp_valid) begin
      if (!seen) begin
        seen = 1'b1;
        held_rdata = bus.resp_rdata;
        held_err = bus.resp_err;
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got rdata %h err %b, required none",
                   bus.resp_rdata, bus.resp_err);
        end else begin
          e = sbq.pop_front();
          chk({e.name, " rdata"}, bus.resp_rdata, e.rdata);
          chk({e.name, " err"}, {31'd0, bus.resp_err}, {31'd0, e.err});
          chk({e.name, " latency"}, ncyc - acc_n, e.lat);
          chk({e.name, " re_cycles"}, re_cnt, e.re);
          chk({e.name, " we_cycles"}, we_cnt, e.we);
          if (e.we != 0) begin
            chk({e.name, " wr_addr"}, {23'd0, last_wa}, {23'd0, e.wa});
            chk({e.name, " wr_data"}, last_wd, e.wd);
          end
        end
      end else begin
        chk("held rdata", bus.resp_rdata, held_rdata);
        chk("held err", {31'd0, bus.resp_err}, {31'd0, held_err});
        chk("held req_ready", {31'd0, bus.req_ready}, 32'd0);
      end
      if (bus.resp_ready) seen = 1'b0;
    end else begin
      seen = 1'b0;
    end
    if (bus.req_valid && bus.req_ready && rst_n) begin
      acc_n = ncyc;
      re_cnt = 0;
      we_cnt = 0;
    end
  end

  task automatic issue(input string nm, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee, input int lat,
                       input int re, input int wc, input logic [8:0] wa,
                       input logic [31:0] ewd);
    exp_t x;
    logic acc;
    x.name = nm; x.rdata = er; x.err = ee; x.lat = lat;
    x.re = re; x.we = wc; x.wa = wa; x.wd = ewd;
    sbq.push_back(x);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_funct3 = f3;
    bus.req_addr = addr;
    bus.req_wdata = wd;
    acc = 1'b0;
    for (int i = 0; i < 60 && !acc; i++) begin
      @(negedge clk);
      acc = bus.req_ready;
      @(posedge clk);
    end
    #1 bus.req_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL %s accept: got no req_ready, required accept within 60 cycles", nm);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (sbq.size() != 0 || bus.resp_valid || !bus.req_ready); i++)
      @(negedge clk);
    chk("drain pending", sbq.size(), 32'd0);
  endtask

  initial begin
    logic got_we;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr = 32'd0;
    bus.req_wdata = 32'd0;
    bus.resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_rst("por");
    @(negedge clk);
    rst_n = 1'b1;
    preload = 1'b0;

    // loads on mem[3] = 812345F6
    issue("LB 0C",  0, 3'b000, 32'h0C, 0, 32'hFFFFFFF6, 0, 2, 1, 0, 0, 0);
    issue("LBU 0F", 0, 3'b100, 32'h0F, 0, 32'h00000081, 0, 2, 1, 0, 0, 0);
    issue("LH 0E",  0, 3'b001, 32'h0E, 0, 32'hFFFF8123, 0, 2, 1, 0, 0, 0);
    issue("LHU 0E", 0, 3'b101, 32'h0E, 0, 32'h00008123, 0, 2, 1, 0, 0, 0);
    issue("LW 0C",  0, 3'b010, 32'h0C, 0, 32'h812345F6, 0, 2, 1, 0, 0, 0);
    issue("LB 0D",  0, 3'b000, 32'h0D, 0, 32'h00000045, 0, 2, 1, 0, 0, 0);
    issue("LH 0C",  0, 3'b001, 32'h0C, 0, 32'h000045F6, 0, 2, 1, 0, 0, 0);
    issue("LBU 0C", 0, 3'b100, 32'h0C, 0, 32'h000000F6, 0, 2, 1, 0, 0, 0);
    // stores
    issue("SB 0D",  1, 3'b000, 32'h0D, 32'h123456AA, 0, 0, 3, 1, 1, 9'd3, 32'h8123AAF6);
    issue("SH 0C",  1, 3'b001, 32'h0C, 32'hFFFF1234, 0, 0, 3, 1, 1, 9'd3, 32'h81231234);
    issue("LW 0C b", 0, 3'b010, 32'h0C, 0, 32'h81231234, 0, 2, 1, 0, 0, 0);
    issue("SW 10",  1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 0, 2, 0, 1, 9'd4, 32'hDEADBEEF);
    issue("LW 10",  0, 3'b010, 32'h10, 0, 32'hDEADBEEF, 0, 2, 1, 0, 0, 0);
    issue("LW 810 wrap", 0, 3'b010, 32'h810, 0, 32'hDEADBEEF, 0, 2, 1, 0, 0, 0);
    // errors
    issue("SH 0D err",  1, 3'b001, 32'h0D, 32'h5555, 0, 1, 1, 0, 0, 0, 0);
    issue("LW 12 err",  0, 3'b010, 32'h12, 0, 0, 1, 1, 0, 0, 0, 0);
    issue("L f3=011",   0, 3'b011, 32'h0C, 0, 0, 1, 1, 0, 0, 0, 0);
    issue("S f3=100",   1, 3'b100, 32'h0C, 32'h77, 0, 1, 1, 0, 0, 0, 0);
    drain();

    // back-pressure: response held for several cycles, next request waits
    bus.resp_ready = 1'b0;
    issue("LW hold", 0, 3'b010, 32'h0C, 0, 32'h81231234, 0, 2, 1, 0, 0, 0);
    fork
      begin
        for (int i = 0; i < 20 && !bus.resp_valid; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        #1 bus.resp_ready = 1'b1;
      end
      issue("LBU after hold", 0, 3'b100, 32'h0F, 0, 32'h00000081, 0, 2, 1, 0, 0, 0);
    join
    drain();

    // reset in the WRITE cycle of an SB aborts it
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.req_we = 1'b1;
    bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h0D;
    bus.req_wdata = 32'h000000CC;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    got_we = 1'b0;
    for (int i = 0; i < 10 && !got_we; i++) begin
      @(negedge clk);
      got_we = mem_we;
    end
    chk("abort reached WRITE", {31'd0, got_we}, 32'd1);
    rst_n = 1'b0;
    #1 check_rst("abort");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("abort mem3 unchanged", mem[3], 32'h81231234);
    issue("LW after rst", 0, 3'b010, 32'h0C, 0, 32'h81231234, 0, 2, 1, 0, 0, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_align.md
# lsu_align

Load/store alignment unit between the execute stage and `datamemory`. It converts byte-addressed RV32 load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into whole-word accesses on the word-indexed data memory. Loads get lane extraction and sign or zero extension. Sub-word stores use a read-modify-write sequence. Misaligned accesses and illegal funct3 codes are rejected with an error response.

## Interface
Parameters:
- DM_ADDRESS, 9: word-index width of the data memory.
- DATA_W, 32: data width. Only 32 is supported.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high exactly when the FSM is in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  instruction bits 14:12.
- req_addr  in  32  byte address (ALU result).
- req_wdata  in  32  store data (rs2).
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  32  load result, already extended. 0 for stores and errors.
- resp_err  out  1  misaligned access or illegal funct3.
- mem_re  out  1  to `datamemory` MemRead.
- mem_we  out  1  to `datamemory` MemWrite.
- mem_funct3  out  3  constant 3'b010 (full-word access).
- mem_addr  out  DM_ADDRESS  word index.
- mem_wdata  out  32  word to write.
- mem_rdata  in  32  combinational read data from memory.

## Operation
- The request handshake completes when req_valid && req_ready at a rising edge. On that edge the unit registers we, funct3, addr[DM_ADDRESS+1:2] as the word index, addr[1:0] as the offset, and wdata.
- Address bits above DM_ADDRESS+1 are ignored, so addresses wrap modulo memory size.
- An access is an error if:
  - funct3 is a load code other than 000/001/010/100/101, or
  - funct3 is a store code other than 000/001/010, or
  - it is a halfword access with offset[0] = 1, or
  - it is a word access with offset ≠ 0.
- FSM states: IDLE, READ, WRITE, RESP.
  - IDLE → RESP on an error request. No memory access occurs.
  - IDLE → READ for loads, SB and SH.
  - IDLE → WRITE for SW.
  - READ → RESP for loads. The extracted, extended result is registered on this edge.
  - READ → WRITE for SB/SH. mem_rdata is registered as the merge base on this edge.
  - WRITE → RESP.
  - RESP → IDLE when resp_ready. Otherwise the unit holds, and resp_* stay stable.
- mem_re is 1 only in READ. mem_we is 1 only in WRITE. mem_addr holds the registered word index in READ and WRITE, and is 0 otherwise.
- Load extraction:
  - Byte lane = word[8·off+7 : 8·off].
  - Halfword lane = word[16·off[1]+15 : 16·off[1]].
  - LB/LH sign-extend from the lane MSB. LBU/LHU zero-extend. LW passes the word unchanged.
- Store merge:
  - SB replaces only byte lane off with wdata[7:0].
  - SH replaces only halfword lane off[1] with wdata[15:0].
  - SW writes wdata unchanged.
- In RESP, resp_err = 1 only for error requests. resp_rdata = 0 for stores and errors.

## Timing
- Reset (rst_n low, asynchronous) forces:
  - state = IDLE, so req_ready = 1;
  - resp_valid = 0, resp_err = 0, resp_rdata = 0;
  - mem_re = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - req_valid is ignored while rst_n is low.
- Reset asserted during READ or WRITE aborts the operation. No write occurs at the next edge, and no response is produced.
- Latency from the accept edge to the first resp_valid cycle:
  - error: 1 cycle;
  - load or SW: 2 cycles;
  - SB/SH: 3 cycles.
- Each response is held for at least one cycle. Back-to-back throughput is bounded: a new request is accepted no earlier than the edge after the RESP → IDLE transition.
- The merge base is captured on the READ edge, so a concurrent memory write from elsewhere is not supported. The unit assumes exclusive ownership of the memory port.

## Test plan
- Preload mem[3] = 0x812345F6. Then:
  - LB addr 0x0C → resp_rdata 0xFFFFFFF6, resp_valid 2 cycles after accept.
  - LBU 0x0F → 0x00000081.
  - LH 0x0E → 0xFFFF8123.
  - LHU 0x0E → 0x00008123.
  - LW 0x0C → 0x812345F6.
- SB addr 0x0D, wdata 0x123456AA on mem[3] = 0x812345F6 → one mem_re cycle, then one mem_we cycle with mem_wdata 0x8123AAF6. resp_valid 3 cycles after accept; resp_err 0.
- SW addr 0x10, wdata 0xDEADBEEF → no mem_re, one mem_we cycle with mem_addr 4. A following LW 0x10 returns 0xDEADBEEF.
- Error cases, each giving resp_err = 1, resp_rdata = 0, one cycle after accept, with mem_re/mem_we never asserted:
  - SH addr 0x0D;
  - LW addr 0x12;
  - load funct3 011.
- Hold resp_ready = 0 for 4 cycles after an LW → resp_valid and resp_rdata stay stable, req_ready stays 0, and a second request is accepted only after the resp_ready handshake.
- Pulse rst_n low during the WRITE cycle of an SB → memory word unchanged, no resp_valid, all outputs at their reset values, req_ready = 1.
